// File: rtl/cu_pkg.sv
// Shared types for the control sequencer: ALU opcodes and FSM states.
package cu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;
endpackage

// File: rtl/control_sequencer_if.sv
// Issue/control bundle between an instruction source (master) and the sequencer (slave).
interface control_sequencer_if #(
  parameter int NUM_REGS  = 4,
  parameter int REG_SEL_W = $clog2(NUM_REGS)
);
  import cu_pkg::*;

  logic                 start;
  opcode_e              opcode;
  logic [REG_SEL_W-1:0] src_a, src_b, dst;
  logic                 ready;
  logic [NUM_REGS-1:0]  reg_out, reg_in;
  logic                 add, sub, mul, div;
  logic                 select_y, yin, zin, zout;
  logic                 end_pulse;

  modport master (
    output start, opcode, src_a, src_b, dst,
    input  ready, reg_out, reg_in, add, sub, mul, div,
           select_y, yin, zin, zout, end_pulse
  );

  modport slave (
    input  start, opcode, src_a, src_b, dst,
    output ready, reg_out, reg_in, add, sub, mul, div,
           select_y, yin, zin, zout, end_pulse
  );
endinterface

// File: rtl/control_step_counter.sv
// Loadable down-counter timing the EXEC phase; freezes when i_en is low.
module control_step_counter #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_en) begin
      if (i_load)
        r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/control_sequencer.sv
// Microcoded-style datapath sequencer: LOAD_Y -> EXEC(n) -> WRITE -> DONE.
// Optional CU_STALL_EN adds an i_stall input that freezes progress.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int REG_SEL_W = $clog2(NUM_REGS),
  parameter int MUL_LAT   = 3,
  parameter int DIV_LAT   = 5
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef CU_STALL_EN
  input  logic i_stall,
`endif
  control_sequencer_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e               r_state;
  opcode_e              r_op;
  logic [REG_SEL_W-1:0] r_src_a, r_src_b, r_dst;
  logic                 w_stall;
  logic                 w_cnt_zero;
  logic [CNT_W-1:0]     w_load_val;

`ifdef CU_STALL_EN
  assign w_stall = i_stall;
`else
  assign w_stall = 1'b0;
`endif

  // Out-of-range selects enable no register at all.
  function automatic logic [NUM_REGS-1:0] f_onehot(input logic [REG_SEL_W-1:0] s);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (int'(s) < NUM_REGS) v[s] = 1'b1;
    return v;
  endfunction

  // Counter holds (EXEC cycles - 1); EXEC exits on the cycle it reads zero.
  always_comb begin
    case (r_op)
      OP_MUL:  w_load_val = CNT_W'(MUL_LAT - 1);
      OP_DIV:  w_load_val = CNT_W'(DIV_LAT - 1);
      default: w_load_val = '0;
    endcase
  end

  control_step_counter #(.W(CNT_W)) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (~w_stall),
    .i_load     (r_state == S_LOAD_Y),
    .i_dec      (r_state == S_EXEC),
    .i_load_val (w_load_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
    end else if (!w_stall) begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op    <= bus.opcode;
          r_src_a <= bus.src_a;
          r_src_b <= bus.src_b;
          r_dst   <= bus.dst;
          r_state <= S_LOAD_Y;
        end
        S_LOAD_Y: r_state <= S_EXEC;
        S_EXEC:   if (w_cnt_zero) r_state <= S_WRITE;
        S_WRITE:  r_state <= S_DONE;
        S_DONE:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Bus enables persist through a stall; register/latch strobes are masked.
  always_comb begin
    bus.ready     = 1'b0;
    bus.reg_out   = '0;
    bus.reg_in    = '0;
    bus.add       = 1'b0;
    bus.sub       = 1'b0;
    bus.mul       = 1'b0;
    bus.div       = 1'b0;
    bus.select_y  = 1'b0;
    bus.yin       = 1'b0;
    bus.zin       = 1'b0;
    bus.zout      = 1'b0;
    bus.end_pulse = 1'b0;
    case (r_state)
      S_IDLE: bus.ready = 1'b1;
      S_LOAD_Y: begin
        bus.reg_out = f_onehot(r_src_a);
        bus.yin     = ~w_stall;
      end
      S_EXEC: begin
        bus.reg_out  = f_onehot(r_src_b);
        bus.select_y = 1'b1;
        bus.zin      = ~w_stall;
        bus.add      = (r_op == OP_ADD);
        bus.sub      = (r_op == OP_SUB);
        bus.mul      = (r_op == OP_MUL);
        bus.div      = (r_op == OP_DIV);
      end
      S_WRITE: begin
        bus.zout   = 1'b1;
        bus.reg_in = w_stall ? '0 : f_onehot(r_dst);
      end
      S_DONE: bus.end_pulse = ~w_stall;
      default: ;
    endcase
  end
endmodule
